// File: rtl/mem_stage_pipe.sv
// -----------------------------------------------------------------------------
// mem_stage_pipe
// -----------------------------------------------------------------------------
// MEM pipeline stage of the LC-3b core, placed between the EX/MEM and MEM/WB
// registers. The stage holds one instruction at a time. For LDR/LDB/LDI-leg/
// STR/STB it runs the data-memory access over a resp-based dcache handshake.
// It then presents the instruction's payload and any load data to writeback
// over a valid/ready interface. Non-memory instructions pass through with one
// cycle of latency.
//
// Ports
//   clk, rst_n        clock and asynchronous active-low reset
//   flush             synchronous kill of the held or incoming instruction
//   in_valid/in_ready EX/MEM handshake
//   in_address        effective data address
//   in_wdata          store data (SR)
//   in_mem_read       instruction loads
//   in_mem_write      instruction stores (wins if read is also set)
//   in_byte           byte access (LDB/STB)
//   in_aluresult, in_npc, in_ir, in_drid, in_cs
//                     payload forwarded unchanged to writeback
//   dmem_read/write   dcache request, held until dmem_resp
//   dmem_address      word-aligned dcache address (bit 0 forced to 0)
//   dmem_wdata        dcache write data (byte replicated for STB)
//   dmem_byte_en      byte enables, bit i = byte i
//   dmem_rdata        dcache read data
//   dmem_resp         dcache completes the request this cycle
//   out_valid/out_ready MEM/WB handshake
//   out_*             registered payload copies
//   out_mdr           load data, 0 for non-loads
//   perf_stall_cnt    saturating count of ACCESS cycles without dmem_resp
// -----------------------------------------------------------------------------
module mem_stage_pipe #(
  parameter int DATA_W = 16,
  parameter int DRID_W = 3,
  parameter int CS_W   = 4,
  parameter int PERF_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  // EX/MEM side
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_address,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic                in_mem_read,
  input  logic                in_mem_write,
  input  logic                in_byte,
  input  logic [DATA_W-1:0]   in_aluresult,
  input  logic [DATA_W-1:0]   in_npc,
  input  logic [DATA_W-1:0]   in_ir,
  input  logic [DRID_W-1:0]   in_drid,
  input  logic [CS_W-1:0]     in_cs,
  // dcache side
  output logic                dmem_read,
  output logic                dmem_write,
  output logic [DATA_W-1:0]   dmem_address,
  output logic [DATA_W-1:0]   dmem_wdata,
  output logic [DATA_W/8-1:0] dmem_byte_en,
  input  logic [DATA_W-1:0]   dmem_rdata,
  input  logic                dmem_resp,
  // MEM/WB side
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_address,
  output logic [DATA_W-1:0]   out_aluresult,
  output logic [DATA_W-1:0]   out_npc,
  output logic [DATA_W-1:0]   out_ir,
  output logic [DRID_W-1:0]   out_drid,
  output logic [CS_W-1:0]     out_cs,
  output logic [DATA_W-1:0]   out_mdr,
  // performance
  output logic [PERF_W-1:0]   perf_stall_cnt
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Data-formatting helpers
  // ---------------------------------------------------------------------------

  // Load data: full word, or the byte picked by address[0], sign-extended.
  function automatic logic [DATA_W-1:0] ld_format(input logic [DATA_W-1:0] rdata,
                                                  input logic              is_byte,
                                                  input logic              a0);
    logic [7:0] b;
    b = a0 ? rdata[15:8] : rdata[7:0];
    if (is_byte) ld_format = {{(DATA_W-8){b[7]}}, b};
    else         ld_format = rdata;
  endfunction

  // Store data: STB places SR[7:0] in every byte lane so the byte enables
  // alone decide which lane gets written.
  function automatic logic [DATA_W-1:0] st_format(input logic [DATA_W-1:0] sr,
                                                  input logic              is_byte);
    if (is_byte) st_format = {BE_W{sr[7:0]}};
    else         st_format = sr;
  endfunction

  function automatic logic [BE_W-1:0] be_format(input logic is_byte,
                                                input logic a0);
    logic [BE_W-1:0] be;
    if (is_byte) begin
      be    = '0;
      be[0] = ~a0;
      be[1] = a0;
    end else begin
      be = '1;
    end
    be_format = be;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e              state_q,  state_d;
  logic                killed_q, killed_d;
  logic                rd_q,     rd_d;
  logic                wr_q,     wr_d;
  logic                byte_q,   byte_d;
  logic [DATA_W-1:0]   addr_q,   addr_d;
  logic [DATA_W-1:0]   wdata_q,  wdata_d;
  logic [DATA_W-1:0]   alu_q,    alu_d;
  logic [DATA_W-1:0]   npc_q,    npc_d;
  logic [DATA_W-1:0]   ir_q,     ir_d;
  logic [DRID_W-1:0]   drid_q,   drid_d;
  logic [CS_W-1:0]     cs_q,     cs_d;
  logic [DATA_W-1:0]   mdr_q,    mdr_d;
  logic [PERF_W-1:0]   perf_q,   perf_d;

  logic in_access;
  logic accept;

  assign in_access = (state_q == S_ACCESS);
  assign in_ready  = ~flush & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
  assign accept    = in_valid & in_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    killed_d = killed_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    byte_d   = byte_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    alu_d    = alu_q;
    npc_d    = npc_q;
    ir_d     = ir_q;
    drid_d   = drid_q;
    cs_d     = cs_q;
    mdr_d    = mdr_q;
    perf_d   = perf_q;

    if (in_access && !dmem_resp && (perf_q != {PERF_W{1'b1}})) begin
      perf_d = perf_q + PERF_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        // flush already blocks accept through in_ready.
        state_d = S_IDLE;
      end
      S_ACCESS: begin
        // The dcache request runs to completion even when flushed; the kill
        // only suppresses the writeback hand-off.
        killed_d = killed_q | flush;
        if (dmem_resp) begin
          killed_d = 1'b0;
          if (killed_q || flush) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DONE;
            if (rd_q) mdr_d = ld_format(dmem_rdata, byte_q, addr_q[0]);
          end
        end
      end
      S_DONE: begin
        if (flush || out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Accept overrides the IDLE/DONE exit above (back-to-back in DONE).
    if (accept) begin
      rd_d     = in_mem_read & ~in_mem_write;
      wr_d     = in_mem_write;
      byte_d   = in_byte;
      addr_d   = in_address;
      wdata_d  = st_format(in_wdata, in_byte);
      alu_d    = in_aluresult;
      npc_d    = in_npc;
      ir_d     = in_ir;
      drid_d   = in_drid;
      cs_d     = in_cs;
      mdr_d    = '0;
      killed_d = 1'b0;
      state_d  = (in_mem_read | in_mem_write) ? S_ACCESS : S_DONE;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      killed_q <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      byte_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      alu_q    <= '0;
      npc_q    <= '0;
      ir_q     <= '0;
      drid_q   <= '0;
      cs_q     <= '0;
      mdr_q    <= '0;
      perf_q   <= '0;
    end else begin
      state_q  <= state_d;
      killed_q <= killed_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      byte_q   <= byte_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      alu_q    <= alu_d;
      npc_q    <= npc_d;
      ir_q     <= ir_d;
      drid_q   <= drid_d;
      cs_q     <= cs_d;
      mdr_q    <= mdr_d;
      perf_q   <= perf_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dmem_read      = in_access & rd_q;
  assign dmem_write     = in_access & wr_q;
  assign dmem_address   = {addr_q[DATA_W-1:1], 1'b0};
  assign dmem_wdata     = wdata_q;
  assign dmem_byte_en   = in_access ? be_format(byte_q, addr_q[0]) : '0;

  assign out_valid      = (state_q == S_DONE);
  assign out_address    = addr_q;
  assign out_aluresult  = alu_q;
  assign out_npc        = npc_q;
  assign out_ir         = ir_q;
  assign out_drid       = drid_q;
  assign out_cs         = cs_q;
  assign out_mdr        = mdr_q;
  assign perf_stall_cnt = perf_q;

endmodule
